// File: rtl/pe_seq_pkg.sv
// Shared types and constants for the parallel_pe sequencer: FSM state encoding,
// pe_ctl bit positions and the instruction word width.
package pe_seq_pkg;

  localparam int INST_W    = 8;
  localparam int CTL_FIRST = 0;
  localparam int CTL_LAST  = 1;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    RUN,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/pe_seq_ctrl_if.sv
// Beat/result bus between the sequencer (master) and parallel_pe (slave).
interface pe_seq_pe_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);

  logic [ADDR_W-1:0] neuron_addr;
  logic [ADDR_W-1:0] weight_addr;
  logic [1:0]        pe_ctl;
  logic              pe_vld_i;
  logic              pe_vld_o;
  logic [DATA_W-1:0] pe_result;

  modport master (
    output neuron_addr, weight_addr, pe_ctl, pe_vld_i,
    input  pe_vld_o, pe_result
  );

  modport slave (
    input  neuron_addr, weight_addr, pe_ctl, pe_vld_i,
    output pe_vld_o, pe_result
  );

endinterface

// File: rtl/pe_seq_retire.sv
// Result retirement: tracks results in flight, writes each PE result to the
// result RAM at a wrapping pointer, and flags results nobody asked for.
module pe_seq_retire #(
  parameter int RES_AW = 2,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              issue_last,
  input  logic              vld_o,
  input  logic [DATA_W-1:0] result,
  output logic [CNT_W-1:0]  outstanding,
  output logic              res_wr_en,
  output logic [RES_AW-1:0] res_wr_addr,
  output logic [DATA_W-1:0] res_wr_data,
  output logic              err
);

  logic [RES_AW-1:0] ptr;
  logic              accept;
  logic              spurious;

  assign accept   = vld_o && (outstanding != '0);
  assign spurious = vld_o && (outstanding == '0);

  // A result arriving in the same cycle as a new last beat leaves the count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
      ptr         <= '0;
      res_wr_en   <= 1'b0;
      res_wr_addr <= '0;
      res_wr_data <= '0;
      err         <= 1'b0;
    end else begin
      res_wr_en <= accept;
      if (accept) begin
        res_wr_addr <= ptr;
        res_wr_data <= result;
      end
      if (clear)
        ptr <= '0;
      else if (accept)
        ptr <= ptr + 1'b1;
      case ({issue_last, accept})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
      if (clear)
        err <= 1'b0;
      else if (spurious)
        err <= 1'b1;
    end
  end

endmodule

// File: rtl/pe_seq_ctrl.sv
// Sequencer for parallel_pe: fetches iteration counts, issues neuron/weight beats,
// retires results. Define PE_SEQ_PERF_EN to add the perf_cyc/perf_stall counters.
module pe_seq_ctrl
  import pe_seq_pkg::*;
#(
  parameter int INST_AW = 2,
  parameter int ADDR_W  = 16,
  parameter int RES_AW  = 2,
  parameter int DATA_W  = 32,
  parameter int MAX_OUT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [INST_AW:0]   inst_num,
  input  logic [ADDR_W-1:0]  neuron_base,
  input  logic [ADDR_W-1:0]  weight_base,
  output logic               inst_rd_en,
  output logic [INST_AW-1:0] inst_rd_addr,
  input  logic [INST_W-1:0]  inst_rd_data,
  pe_seq_pe_if.master        pe,
  output logic               res_wr_en,
  output logic [RES_AW-1:0]  res_wr_addr,
  output logic [DATA_W-1:0]  res_wr_data,
  output logic               busy,
  output logic               done,
  output logic               err
`ifdef PE_SEQ_PERF_EN
  ,
  output logic [31:0]        perf_cyc,
  output logic [31:0]        perf_stall
`endif
);

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] MAX_OUT_C = CNT_W'(MAX_OUT);

  state_t             state, state_nx;
  logic [INST_AW:0]   pc_q;
  logic [INST_AW:0]   num_q;
  logic [INST_W-1:0]  n_q;
  logic [INST_W-1:0]  iter_q;
  logic [ADDR_W-1:0]  nptr;
  logic [ADDR_W-1:0]  wptr;
  logic [CNT_W-1:0]   outstanding;
  logic               start_acc;
  logic               can_fetch;
  logic               is_last_instr;
  logic               last_beat;

  assign start_acc     = (state == IDLE) && start;
  assign can_fetch     = (outstanding < MAX_OUT_C);
  assign is_last_instr = (pc_q == num_q - 1'b1);
  assign last_beat     = (state == RUN) && (iter_q == n_q - 1'b1);

  assign inst_rd_addr   = pc_q[INST_AW-1:0];
  assign pe.neuron_addr = nptr;
  assign pe.weight_addr = wptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // Every output decodes only registered state, so nothing combinational reaches the ports.
  always_comb begin
    state_nx    = state;
    inst_rd_en  = 1'b0;
    busy        = (state != IDLE);
    done        = (state == DONE);
    pe.pe_vld_i = (state == RUN);
    pe.pe_ctl   = 2'b00;
    pe.pe_ctl[CTL_FIRST] = (state == RUN) && (iter_q == '0);
    pe.pe_ctl[CTL_LAST]  = last_beat;
    case (state)
      IDLE:
        if (start)
          state_nx = FETCH;
      FETCH:
        if (num_q == '0)
          state_nx = DONE;
        else if (can_fetch) begin
          inst_rd_en = 1'b1;
          state_nx   = LOAD;
        end
      LOAD:
        if (inst_rd_data == '0)
          state_nx = is_last_instr ? DRAIN : FETCH;
        else
          state_nx = RUN;
      RUN:
        if (last_beat)
          state_nx = is_last_instr ? DRAIN : FETCH;
      DRAIN:
        if (outstanding == '0)
          state_nx = DONE;
      DONE:
        state_nx = IDLE;
      default:
        state_nx = IDLE;
    endcase
  end

  // Addresses keep counting across instructions so the next program slice follows on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= '0;
      num_q  <= '0;
      n_q    <= '0;
      iter_q <= '0;
      nptr   <= '0;
      wptr   <= '0;
    end else begin
      if (start_acc) begin
        pc_q  <= '0;
        num_q <= inst_num;
        nptr  <= neuron_base;
        wptr  <= weight_base;
      end
      if (state == LOAD) begin
        if (inst_rd_data == '0)
          pc_q <= pc_q + 1'b1;
        else begin
          n_q    <= inst_rd_data;
          iter_q <= '0;
        end
      end
      if (state == RUN) begin
        nptr   <= nptr + 1'b1;
        wptr   <= wptr + 1'b1;
        iter_q <= iter_q + 1'b1;
        if (last_beat)
          pc_q <= pc_q + 1'b1;
      end
    end
  end

  pe_seq_retire #(
    .RES_AW (RES_AW),
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_retire (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (start_acc),
    .issue_last  (last_beat),
    .vld_o       (pe.pe_vld_o),
    .result      (pe.pe_result),
    .outstanding (outstanding),
    .res_wr_en   (res_wr_en),
    .res_wr_addr (res_wr_addr),
    .res_wr_data (res_wr_data),
    .err         (err)
  );

`ifdef PE_SEQ_PERF_EN
  logic fetch_stall;
  assign fetch_stall = (state == FETCH) && (num_q != '0) && !can_fetch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cyc   <= '0;
      perf_stall <= '0;
    end else if (start_acc) begin
      perf_cyc   <= '0;
      perf_stall <= '0;
    end else begin
      if (busy && (perf_cyc != '1))
        perf_cyc <= perf_cyc + 1'b1;
      if (fetch_stall && (perf_stall != '1))
        perf_stall <= perf_stall + 1'b1;
    end
  end
`endif

endmodule
